// File: rtl/rv151_bpd.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by PC,
// with a registered mispredict pulse and saturating branch/mispredict counters.
module rv151_bpd #(
    parameter int BPD_IDX_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bpd_req_vld,
    input  logic [31:0] bpd_req_pc,
    output logic        bpd_pred_tk,
    input  logic        bpd_rsv_vld,
    input  logic [31:0] bpd_rsv_pc,
    input  logic        bpd_rsv_tk,
    input  logic        bpd_rsv_pd,
    output logic        bpd_mispred,
    output logic [31:0] bpd_cnt_bch,
    output logic [31:0] bpd_cnt_mis
);

    localparam int ENTRIES = 1 << BPD_IDX_W;

    logic [1:0]           bht_q [ENTRIES];
    logic [BPD_IDX_W-1:0] req_idx;
    logic [BPD_IDX_W-1:0] rsv_idx;
    logic [1:0]           rsv_cur;
    logic [1:0]           rsv_nxt;
    logic                 mis_now;
    logic                 mispred_q;
    logic [31:0]          cnt_bch_q;
    logic [31:0]          cnt_mis_q;

    assign req_idx = bpd_req_pc[BPD_IDX_W+1:2];
    assign rsv_idx = bpd_rsv_pc[BPD_IDX_W+1:2];

    // Prediction reads the stored value directly, so a same-cycle update is not bypassed.
    assign bpd_pred_tk = bpd_req_vld & bht_q[req_idx][1];

    assign rsv_cur = bht_q[rsv_idx];
    assign mis_now = bpd_rsv_vld & (bpd_rsv_tk ^ bpd_rsv_pd);

    always_comb begin
        rsv_nxt = rsv_cur;
        if (bpd_rsv_tk) begin
            if (rsv_cur != 2'b11) rsv_nxt = rsv_cur + 2'b01;
        end else begin
            if (rsv_cur != 2'b00) rsv_nxt = rsv_cur - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (bpd_rsv_vld) begin
            bht_q[rsv_idx] <= rsv_nxt;
        end
    end

    // Statistics counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            mispred_q <= 1'b0;
            cnt_bch_q <= '0;
            cnt_mis_q <= '0;
        end else begin
            mispred_q <= mis_now;
            if (bpd_rsv_vld && cnt_bch_q != 32'hFFFF_FFFF) cnt_bch_q <= cnt_bch_q + 32'd1;
            if (mis_now && cnt_mis_q != 32'hFFFF_FFFF) cnt_mis_q <= cnt_mis_q + 32'd1;
        end
    end

    assign bpd_mispred = mispred_q;
    assign bpd_cnt_bch = cnt_bch_q;
    assign bpd_cnt_mis = cnt_mis_q;

endmodule

// File: doc/rv151_bpd.md
RV151_BPD -- requirements
Module: rv151_bpd

Interface
REQ-001 Parameter: BPD_IDX_W, default 5, meaning log2 of branch-history-table entries (32 entries).
REQ-002 Port: clk  input  1  core clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: bpd_req_vld  input  1  fetch stage presents a PC for prediction.
REQ-005 Port: bpd_req_pc  input  32  fetch PC.
REQ-006 Port: bpd_pred_tk  output  1  predicted taken for bpd_req_pc.
REQ-007 Port: bpd_rsv_vld  input  1  execute stage resolves a conditional branch this cycle.
REQ-008 Port: bpd_rsv_pc  input  32  PC of the resolving branch.
REQ-009 Port: bpd_rsv_tk  input  1  actual outcome from the branch comparator's taken output.
REQ-010 Port: bpd_rsv_pd  input  1  prediction originally issued for that branch, carried down the pipeline.
REQ-011 Port: bpd_mispred  output  1  registered mispredict pulse.
REQ-012 Port: bpd_cnt_bch  output  32  resolved-branch counter.
REQ-013 Port: bpd_cnt_mis  output  32  mispredict counter.

Function
REQ-014 Table SHALL hold 2**BPD_IDX_W 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-015 Index SHALL be pc[BPD_IDX_W+1:2]; pc[1:0] and upper bits ignored (no tags, aliasing permitted).
REQ-016 bpd_pred_tk SHALL be combinational: bpd_req_vld AND bit[1] of counter at request index; 0 when bpd_req_vld=0.
REQ-017 On a clock edge with bpd_rsv_vld=1 and rst=0, counter at resolve index SHALL increment if bpd_rsv_tk=1 (saturate at 11), else decrement (saturate at 00).
REQ-018 Exactly one entry SHALL change per update; bpd_rsv_vld=0 leaves the table unchanged.
REQ-019 Same-cycle request and resolve to the same index: bpd_pred_tk SHALL reflect the pre-update value (no bypass).
REQ-020 bpd_mispred SHALL equal, one cycle after the resolve, bpd_rsv_vld AND (bpd_rsv_tk XOR bpd_rsv_pd); it is a single-cycle pulse per mispredicting resolve and 0 otherwise.
REQ-021 Back-to-back resolves SHALL each produce their own mispred value in consecutive cycles (latency 1, throughput 1/cycle).
REQ-022 bpd_cnt_bch SHALL increment by 1 on each edge with bpd_rsv_vld=1, saturating at 32'hFFFF_FFFF.
REQ-023 bpd_cnt_mis SHALL increment by 1 on each edge with a mispredicting resolve, saturating at 32'hFFFF_FFFF; updates same edge as bpd_cnt_bch.
REQ-024 Counter outputs SHALL be register outputs, visible the cycle after the resolve edge.
REQ-025 bpd_rsv_pd is taken as given; the block SHALL NOT recompute the prediction at resolve time.

Reset
REQ-026 With rst=1 at a clock edge, every table entry SHALL become 01 (weak-NT).
REQ-027 With rst=1 at a clock edge, bpd_mispred, bpd_cnt_bch and bpd_cnt_mis SHALL become 0.
REQ-028 rst SHALL take priority over a simultaneous resolve; that resolve is discarded (no table, counter or mispred effect).
REQ-029 bpd_pred_tk after reset SHALL be 0 for every PC until an update occurs.

Verification
REQ-030 Reset, then req pc=0x0000_0040 vld=1 -> bpd_pred_tk=0; cnt_bch=0, cnt_mis=0.
REQ-031 Resolve pc=0x40 tk=1 pd=0 -> next cycle bpd_mispred=1, cnt_bch=1, cnt_mis=1; req pc=0x40 -> pred_tk=1 (entry 10).
REQ-032 Four more resolves pc=0x40 tk=1 pd=1 -> entry saturates 11, mispred=0 each, cnt_bch=5, cnt_mis=1; one resolve tk=0 pd=1 -> mispred=1, pred_tk still 1 (entry 10).
REQ-033 Aliasing: update pc=0x40 to taken, req pc=0xC0 (BPD_IDX_W=5) -> pred_tk=1; req pc=0x44 -> pred_tk=0.
REQ-034 Same-cycle req and resolve pc=0x80 tk=1 from 01 -> pred_tk=0 that cycle, 1 the next cycle.
REQ-035 Resolve with mispredict and rst=1 on same edge -> mispred=0, counters 0, entry 01; force cnt_mis to FFFF_FFFF via long run or preload -> further mispredicts keep FFFF_FFFF.
